// File: rtl/breakout_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : breakout_pkg                                              |
// | Brief    : Game-state encoding shared by the Breakout controller.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package breakout_pkg;

  localparam int STATE_W = 3;

  // Encoding 3 (PAUSE) stays reserved even when pause support is compiled out.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_WIN   = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/breakout_btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : breakout_btn_edge                                         |
// | Brief    : Press detector for an active-low, pre-synchronised button.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module breakout_btn_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_o
);

  logic prev_q;
  logic armed_q;

  // armed_q masks the first cycle after reset so a button held through reset
  // is absorbed into the history register instead of reading as a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= btn_n_i;
      armed_q <= 1'b1;
    end
  end

  assign press_o = armed_q & prev_q & ~btn_n_i;

endmodule
`default_nettype wire

// File: rtl/breakout_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : breakout_game_ctrl                                        |
// | Brief    : Breakout game-state controller: brick bitmap, lives,      |
// |            score, level and serve/play/win/over sequencing.          |
// |            Optional pause support: define BREAKOUT_PAUSE_EN.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int ROWS        = 2,
  parameter int COLS        = 8,
  parameter int LIVES       = 3,
  parameter int MAX_LEVEL   = 4,
  parameter int SERVE_TICKS = 60,
  parameter int SCORE_W     = 16,
  localparam int RW_P       = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW_P       = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int LW_P       = $clog2(MAX_LEVEL) + 1
) (
  input  logic                   clk_50,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   strt,
  input  logic                   pause,
  input  logic                   brick_hit_vld,
  input  logic [RW_P-1:0]        brick_hit_row,
  input  logic [CW_P-1:0]        brick_hit_col,
  input  logic                   ball_lost,
  output logic [ROWS*COLS-1:0]   brick_alive,
  output logic [STATE_W-1:0]     state,
  output logic [3:0]             lives,
  output logic [SCORE_W-1:0]     score,
  output logic [LW_P-1:0]        level,
  output logic                   ball_en,
  output logic                   ball_serve,
  output logic                   win,
  output logic                   lose
);

  localparam int N       = ROWS * COLS;
  localparam int IW      = (N > 1) ? $clog2(N) : 1;
  localparam int SW      = (SERVE_TICKS > 0) ? $clog2(SERVE_TICKS + 1) : 1;
  localparam int SCW     = SCORE_W + 1;
  localparam logic [SW-1:0]   SRV_LAST   = (SERVE_TICKS > 0) ? SW'(SERVE_TICKS - 1) : '0;
  localparam logic [LW_P-1:0] LVL_LAST   = LW_P'(MAX_LEVEL - 1);
  localparam logic [3:0]      LIVES_INIT = 4'(LIVES);

  state_e              state_q, state_d;
  logic [N-1:0]        alive_q, alive_d;
  logic [3:0]          lives_q, lives_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LW_P-1:0]     level_q, level_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic                serve_q, serve_d;
  logic                ball_en_q, win_q, lose_q;

  logic                w_strt_press;
  logic                w_pause_press;

  breakout_btn_edge u_strt_edge (
    .clk_i   (clk_50),
    .rst_i   (rst),
    .btn_n_i (strt),
    .press_o (w_strt_press)
  );

  breakout_btn_edge u_pause_edge (
    .clk_i   (clk_50),
    .rst_i   (rst),
    .btn_n_i (pause),
    .press_o (w_pause_press)
  );

`ifndef BREAKOUT_PAUSE_EN
  logic w_unused_pause;
  assign w_unused_pause = w_pause_press;
`endif

  logic              w_in_range;
  logic [IW-1:0]     w_idx;
  logic [N-1:0]      w_mask;
  logic [N-1:0]      w_alive_hit;
  logic              w_hit;
  logic [SCW-1:0]    w_add;
  logic [SCORE_W-1:0] w_score_sat;

  assign w_in_range  = (32'(brick_hit_row) < ROWS) && (32'(brick_hit_col) < COLS);
  assign w_idx       = IW'(brick_hit_row) * IW'(COLS) + IW'(brick_hit_col);
  assign w_mask      = N'(1) << w_idx;
  assign w_alive_hit = alive_q & ~w_mask;
  assign w_hit       = brick_hit_vld && w_in_range && ((alive_q & w_mask) != '0);
  // Top rows are worth more: row r scores ROWS - r.
  assign w_add       = {1'b0, score_q} + SCW'(ROWS - 32'(brick_hit_row));
  assign w_score_sat = w_add[SCORE_W] ? '1 : w_add[SCORE_W-1:0];

  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    lives_d = lives_q;
    score_d = score_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    serve_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_strt_press) begin
          alive_d = '1;
          lives_d = LIVES_INIT;
          score_d = '0;
          level_d = '0;
          cnt_d   = '0;
          state_d = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (SERVE_TICKS == 0) begin
          serve_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_PLAY;
        end else if (tick) begin
          if (cnt_q == SRV_LAST) begin
            serve_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
      end

      ST_PLAY: begin
        if (w_hit) begin
          alive_d = w_alive_hit;
          score_d = w_score_sat;
        end
        // A grid-clearing hit wins over a simultaneous ball loss.
        if (w_hit && (w_alive_hit == '0)) begin
          cnt_d = '0;
          if (level_q == LVL_LAST) begin
            state_d = ST_WIN;
          end else begin
            level_d = level_q + LW_P'(1);
            alive_d = '1;
            state_d = ST_SERVE;
          end
        end else if (ball_lost) begin
          lives_d = lives_q - 4'd1;
          cnt_d   = '0;
          state_d = (lives_q == 4'd1) ? ST_OVER : ST_SERVE;
        end
`ifdef BREAKOUT_PAUSE_EN
        else if (w_pause_press) begin
          state_d = ST_PAUSE;
        end
`endif
      end

      ST_PAUSE: begin
`ifdef BREAKOUT_PAUSE_EN
        if (w_pause_press) begin
          state_d = ST_PLAY;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_WIN, ST_OVER: begin
        if (w_strt_press) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      alive_q   <= '1;
      lives_q   <= LIVES_INIT;
      score_q   <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      serve_q   <= 1'b0;
      ball_en_q <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      serve_q   <= serve_d;
      ball_en_q <= (state_d == ST_PLAY);
      win_q     <= (state_d == ST_WIN);
      lose_q    <= (state_d == ST_OVER);
    end
  end

  assign brick_alive = alive_q;
  assign state       = state_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign level       = level_q;
  assign ball_en     = ball_en_q;
  assign ball_serve  = serve_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule
`default_nettype wire

// File: doc/breakout_game_ctrl.md
# breakout_game_ctrl

Parametrised game-state controller for the Breakout design. It owns the brick-alive bitmap for an arbitrary ROWS×COLS grid and tracks lives, score and level. It sequences serve, play, pause, life-lost, win and game-over phases. It sits between the ball/brick collision logic, which reports hits and ball loss, and the display path, which draws bricks and status from the bitmap and state outputs.

## Interface
Parameters:
- ROWS, 2, brick rows (row 0 = top)
- COLS, 8, brick columns
- LIVES, 3, lives per game (1..15)
- MAX_LEVEL, 4, levels per game; clearing the last level wins
- SERVE_TICKS, 60, frame ticks the ball is held before each serve
- SCORE_W, 16, score width

Ports:
- clk_50  in  1  system clock; every register is clocked on its rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle frame strobe (60 Hz)
- strt  in  1  start button, active-low level, already synchronised
- pause  in  1  pause button, active-low level, already synchronised
- brick_hit_vld  in  1  collision report strobe
- brick_hit_row  in  $clog2(ROWS)  row of the hit brick
- brick_hit_col  in  $clog2(COLS)  column of the hit brick
- ball_lost  in  1  one-cycle strobe: ball passed the paddle
- brick_alive  out  ROWS*COLS  bit row*COLS+col = 1 when that brick stands
- state  out  3  current game state (package encoding)
- lives  out  4  remaining lives
- score  out  SCORE_W  accumulated score
- level  out  $clog2(MAX_LEVEL)+1  current level, 0-based
- ball_en  out  1  ball motion enable
- ball_serve  out  1  one-cycle pulse telling the ball block to re-centre and launch
- win, lose  out  1  level flags, held high while in WIN / OVER

## Operation
- Button presses are falling edges of strt/pause. The block keeps a registered previous value of each; press = prev & ~cur.
- States: IDLE, SERVE, PLAY, PAUSE, WIN, OVER.
- IDLE: ball_en=0. On a strt press: brick_alive ← all ones, lives ← LIVES, score ← 0, level ← 0, serve counter ← 0, then go to SERVE.
- SERVE: ball_en=0. The counter increments on each tick. At the tick that reaches SERVE_TICKS, ball_serve pulses in the same cycle as the move to PLAY, and the counter clears.
- PLAY: ball_en=1.
  - Valid hit on an alive brick: clear its bit and add ROWS−row to score. Score saturates at all ones.
  - Hit on an already-dead brick, or with row≥ROWS or col≥COLS: ignored, no score.
  - If the hit clears the last alive bit: when level==MAX_LEVEL−1, go to WIN; otherwise level+1, refill all bricks, go to SERVE.
  - ball_lost: lives−1. If the new value is 0, go to OVER; otherwise go to SERVE. The bitmap is kept.
  - A pause press goes to PAUSE (only when compiled in).
- PAUSE: ball_en=0. Hits, ball_lost and tick are ignored. A pause press returns to PLAY without a serve.
- WIN (win=1) / OVER (lose=1): ball_en=0, all outputs frozen. A strt press goes to IDLE.
- Simultaneous hit and ball_lost in PLAY: the hit is applied first.
  - If the hit clears the grid, the level/win transition is taken and the loss is discarded.
  - Otherwise both apply: score updates and lives decrement.
- Simultaneous strt and pause presses in PLAY: pause wins; strt is ignored outside IDLE/WIN/OVER.

## Timing
- All outputs are registered and reflect an input event one clk_50 cycle after the strobe.
- Reset values: state=IDLE, brick_alive all ones, lives=LIVES, score=0, level=0, ball_en=0, ball_serve=0, win=0, lose=0. Button history registers reset to 1 (released).
- rst during any state overrides everything in the same edge; a held button does not produce a press on release of reset.
- Serve latency from entering SERVE to the ball_serve pulse is exactly SERVE_TICKS tick strobes. With SERVE_TICKS=0, the pulse comes on the first cycle in SERVE.

## Configuration
- BREAKOUT_PAUSE_EN defined: PAUSE state and the pause port logic are present as described.
- BREAKOUT_PAUSE_EN undefined: the pause input is ignored, the PAUSE state is unreachable and its encoding remains reserved. PLAY behaviour is otherwise identical.

## Structure
- Package breakout_pkg holds the state encoding constants (IDLE=0, SERVE=1, PLAY=2, PAUSE=3, WIN=4, OVER=5) and the state width.
- One sub-module, breakout_btn_edge (history register plus active-low press detect), is instantiated twice, for strt and pause.

## Test plan
- Reset then strt press → SERVE; ball_serve pulses after exactly 60 ticks with state=PLAY, and brick_alive=16'hFFFF.
- Hit row 0 col 3, then repeat the same hit → bit 3 cleared, score=2; the second hit leaves score=2.
- Three ball_lost strobes with a serve between each → lives 2, 1, 0; state=OVER, lose=1, ball_en=0.
- Clear all 16 bricks at level 0 → level=1, bitmap refilled, state=SERVE; clearing level 3 gives state=WIN, win=1.
- Last-brick hit coincident with ball_lost at lives=1 → level advances and lives stay 1.
- Pause press in PLAY, then hits and ball_lost → all ignored; a second press returns to PLAY. With BREAKOUT_PAUSE_EN undefined, state stays PLAY.
